// File: rtl/byte_wb_master.sv
// rtl/byte_wb_master.sv - byte-stream command frames to single 32-bit Wishbone classic cycles
module byte_wb_master #(
    parameter int BUS_TIMEOUT   = 256,
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic        system_clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i
);

    localparam int BCW = $clog2(BUS_TIMEOUT);
    localparam int FCW = $clog2(FRAME_TIMEOUT);
    localparam logic [BCW-1:0] BUS_LAST = BCW'(BUS_TIMEOUT - 1);
    localparam logic [FCW-1:0] FRM_LAST = FCW'(FRAME_TIMEOUT - 1);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;
    localparam logic [7:0] RSP_RD  = 8'h72;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run;
    logic            r_we;
    logic            r_cyc;
    logic [31:0]     r_adr;
    logic [31:0]     r_dat;
    logic [31:0]     r_rdata;
    logic [1:0]      r_byte_cnt;
    logic [BCW-1:0]  r_bus_cnt;
    logic [FCW-1:0]  r_idle_cnt;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;
    logic            r_resp_rd;
    logic [2:0]      r_resp_idx;

    logic            w_rx_fire;
    logic            w_tx_fire;
    logic            w_last_byte;
    logic            w_bus_to;
    logic            w_frame_to;
    logic            w_resp_done;
    logic            w_cmd_ok;
    logic [7:0]      w_next_byte;

    // r_run keeps rx_ready low during reset and for the release edge itself
    assign rx_ready = r_run && (r_state == S_IDLE || r_state == S_ADDR || r_state == S_DATA);
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;

    assign w_rx_fire   = rx_valid && rx_ready;
    assign w_tx_fire   = r_tx_valid && tx_ready;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_cmd_ok    = (rx_data == CMD_WR) || (rx_data == CMD_RD);
    assign w_bus_to    = (r_state == S_BUS) && !wb_ack_i && (r_bus_cnt == BUS_LAST);
    assign w_frame_to  = (r_state == S_ADDR || r_state == S_DATA) && !w_rx_fire
                         && (r_idle_cnt == FRM_LAST);
    assign w_resp_done = w_tx_fire && (!r_resp_rd || r_resp_idx == 3'd4);

    always_comb begin
        w_next_byte = r_rdata[7:0];
        case (r_resp_idx)
            3'd0:    w_next_byte = r_rdata[31:24];
            3'd1:    w_next_byte = r_rdata[23:16];
            3'd2:    w_next_byte = r_rdata[15:8];
            default: w_next_byte = r_rdata[7:0];
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    w_state_nxt = w_cmd_ok ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                if (w_rx_fire && w_last_byte) begin
                    w_state_nxt = r_we ? S_DATA : S_BUS;
                end else if (w_frame_to) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_rx_fire && w_last_byte) begin
                    w_state_nxt = S_BUS;
                end else if (w_frame_to) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUS: begin
                if (wb_ack_i || w_bus_to) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_resp_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_we       <= 1'b0;
            r_cyc      <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_rdata    <= '0;
            r_byte_cnt <= '0;
            r_bus_cnt  <= '0;
            r_idle_cnt <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_resp_rd  <= 1'b0;
            r_resp_idx <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        r_byte_cnt <= '0;
                        r_idle_cnt <= '0;
                        if (w_cmd_ok) begin
                            r_we <= (rx_data == CMD_WR);
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= RSP_NAK;
                            r_resp_rd  <= 1'b0;
                            r_resp_idx <= '0;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        r_adr      <= {r_adr[23:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_idle_cnt <= '0;
                        if (w_last_byte && !r_we) begin
                            r_cyc     <= 1'b1;
                            r_bus_cnt <= '0;
                        end
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_dat      <= {r_dat[23:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_idle_cnt <= '0;
                        if (w_last_byte) begin
                            r_cyc     <= 1'b1;
                            r_bus_cnt <= '0;
                        end
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                S_BUS: begin
                    // an ack on the final timeout cycle still wins
                    if (wb_ack_i) begin
                        r_cyc      <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= r_we ? RSP_ACK : RSP_RD;
                        r_resp_rd  <= !r_we;
                        r_resp_idx <= '0;
                        if (!r_we) begin
                            r_rdata <= wb_dat_i;
                        end
                    end else if (w_bus_to) begin
                        r_cyc      <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= RSP_NAK;
                        r_resp_rd  <= 1'b0;
                        r_resp_idx <= '0;
                    end else begin
                        r_bus_cnt <= r_bus_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_tx_valid <= 1'b0;
                    end else if (w_tx_fire) begin
                        r_tx_data  <= w_next_byte;
                        r_resp_idx <= r_resp_idx + 3'd1;
                    end
                end
                default: begin
                    r_cyc      <= 1'b0;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_wb_master.sv
// tb/tb_byte_wb_master.sv - directed bench for byte_wb_master
module tb_byte_wb_master;

    localparam int BT  = 8;
    localparam int FT  = 20;
    localparam int LIM = 200;

    logic        system_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    int checks   = 0;
    int failures = 0;

    always #5 system_clk = ~system_clk;

    byte_wb_master #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_ack_i   (wb_ack_i),
        .wb_dat_i   (wb_dat_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < LIM) begin
            @(negedge system_clk);
            n++;
        end
        chk("rx_ready", rx_ready, 1);
        @(negedge system_clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr,
                              input logic [31:0] dat, input bit with_data);
        send(cmd);
        for (int i = 3; i >= 0; i--) send(adr[8*i +: 8]);
        if (with_data) begin
            for (int i = 3; i >= 0; i--) send(dat[8*i +: 8]);
        end
    endtask

    task automatic wb_slave(input string tag, input logic [31:0] eadr, input logic [31:0] edat,
                            input logic ewe, input int delay, input logic [31:0] rdat);
        int n;
        n = 0;
        while (wb_cyc_o !== 1'b1 && n < LIM) begin
            @(negedge system_clk);
            n++;
        end
        chk({tag, "_cyc_latency"}, n, 0);
        chk({tag, "_stb"}, wb_stb_o, 1);
        chk({tag, "_adr"}, wb_adr_o, eadr);
        chk({tag, "_we"}, wb_we_o, ewe);
        chk({tag, "_sel"}, wb_sel_o, 4'hF);
        if (ewe) chk({tag, "_dat"}, wb_dat_o, edat);
        for (int i = 0; i < delay; i++) begin
            @(negedge system_clk);
            chk({tag, "_cyc_hold"}, wb_cyc_o, 1);
            chk({tag, "_adr_hold"}, wb_adr_o, eadr);
            chk({tag, "_tx_quiet"}, tx_valid, 0);
        end
        wb_ack_i = 1'b1;
        wb_dat_i = rdat;
        @(negedge system_clk);
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        chk({tag, "_cyc_drop"}, wb_cyc_o, 0);
        chk({tag, "_tx_first"}, tx_valid, 1);
    endtask

    task automatic recv(input string tag, input logic [7:0] exp, input bit toggle);
        int n;
        n = 0;
        while (tx_valid !== 1'b1 && n < LIM) begin
            @(negedge system_clk);
            n++;
        end
        chk({tag, "_valid"}, tx_valid, 1);
        if (toggle) begin
            tx_ready = 1'b0;
            @(negedge system_clk);
            chk({tag, "_stall_valid"}, tx_valid, 1);
            chk({tag, "_stall_data"}, tx_data, exp);
        end
        chk(tag, tx_data, exp);
        tx_ready = 1'b1;
        @(negedge system_clk);
        tx_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        repeat (3) @(negedge system_clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 4'hF);
        rst_n = 1'b1;
        @(negedge system_clk);
        chk("rel_rx_ready", rx_ready, 1);

        // T1 write, ack after 3 extra cycles
        send_frame(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        wb_slave("t1", 32'h10, 32'hDEAD_BEEF, 1'b1, 3, 32'h0);
        recv("t1_resp", 8'h06, 1'b0);
        chk("t1_idle_tx", tx_valid, 0);
        chk("t1_idle_rx", rx_ready, 1);

        // T2 read, immediate ack, stalled sink
        send_frame(8'h52, 32'h0000_0014, 32'h0, 1'b0);
        wb_slave("t2", 32'h14, 32'h0, 1'b0, 0, 32'h1234_5678);
        recv("t2_b0", 8'h72, 1'b1);
        recv("t2_b1", 8'h12, 1'b1);
        recv("t2_b2", 8'h34, 1'b1);
        recv("t2_b3", 8'h56, 1'b1);
        recv("t2_b4", 8'h78, 1'b1);
        chk("t2_done_tx", tx_valid, 0);

        // T3 bus timeout
        send_frame(8'h57, 32'h0000_0018, 32'hCAFE_F00D, 1'b1);
        n = 0;
        while (wb_cyc_o === 1'b1 && n < LIM) begin
            n++;
            @(negedge system_clk);
        end
        chk("t3_cyc_cycles", n, BT);
        chk("t3_tx_first", tx_valid, 1);
        recv("t3_resp", 8'h15, 1'b0);
        chk("t3_idle_rx", rx_ready, 1);

        // T4 bad command, then a good read
        send(8'hA5);
        chk("t4_no_cyc", wb_cyc_o, 0);
        recv("t4_resp", 8'h15, 1'b0);
        chk("t4_no_cyc2", wb_cyc_o, 0);
        send_frame(8'h52, 32'h0000_001C, 32'h0, 1'b0);
        wb_slave("t4r", 32'h1C, 32'h0, 1'b0, 0, 32'hA5A5_5A5A);
        recv("t4_b0", 8'h72, 1'b0);
        recv("t4_b1", 8'hA5, 1'b0);
        recv("t4_b2", 8'hA5, 1'b0);
        recv("t4_b3", 8'h5A, 1'b0);
        recv("t4_b4", 8'h5A, 1'b0);

        // T5a gap one short of the frame timeout keeps the frame alive
        send(8'h52);
        send(8'h00);
        repeat (FT - 1) @(negedge system_clk);
        send(8'h00);
        send(8'h00);
        send(8'h30);
        wb_slave("t5a", 32'h30, 32'h0, 1'b0, 0, 32'h0102_0304);
        recv("t5a_b0", 8'h72, 1'b0);
        recv("t5a_b1", 8'h01, 1'b0);
        recv("t5a_b2", 8'h02, 1'b0);
        recv("t5a_b3", 8'h03, 1'b0);
        recv("t5a_b4", 8'h04, 1'b0);

        // T5b full timeout discards the partial frame silently
        send(8'h52);
        send(8'h00);
        send(8'h00);
        repeat (FT) @(negedge system_clk);
        chk("t5_no_tx", tx_valid, 0);
        chk("t5_no_cyc", wb_cyc_o, 0);
        send_frame(8'h52, 32'h0000_0020, 32'h0, 1'b0);
        wb_slave("t5b", 32'h20, 32'h0, 1'b0, 0, 32'h0BAD_F00D);
        recv("t5b_b0", 8'h72, 1'b0);
        recv("t5b_b1", 8'h0B, 1'b0);
        recv("t5b_b2", 8'hAD, 1'b0);
        recv("t5b_b3", 8'hF0, 1'b0);
        recv("t5b_b4", 8'h0D, 1'b0);

        // T6 reset during a bus cycle
        send_frame(8'h57, 32'h0000_0040, 32'h1122_3344, 1'b1);
        chk("t6_cyc_up", wb_cyc_o, 1);
        rst_n = 1'b0;
        @(negedge system_clk);
        chk("t6_cyc", wb_cyc_o, 0);
        chk("t6_stb", wb_stb_o, 0);
        chk("t6_tx_valid", tx_valid, 0);
        chk("t6_rx_ready", rx_ready, 0);
        chk("t6_adr", wb_adr_o, 0);
        rst_n = 1'b1;
        @(negedge system_clk);
        chk("t6_rel_rx", rx_ready, 1);
        repeat (5) @(negedge system_clk);
        chk("t6_no_resp", tx_valid, 0);
        send_frame(8'h57, 32'h0000_0044, 32'h5566_7788, 1'b1);
        wb_slave("t6w", 32'h44, 32'h5566_7788, 1'b1, 1, 32'h0);
        recv("t6_resp", 8'h06, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
